// File: rtl/uart_rx_if.sv
// CPU memory-bus bundle between the bus interconnect and the UART receiver.
// The master side drives the request; the slave side answers with a one-cycle ready pulse.
interface uart_rx_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              enable;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_instr;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output enable, mem_valid, mem_instr, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  enable, mem_valid, mem_instr, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, a small receive FIFO and a CPU
// register view (DATA at bit2 = 0, STATUS at bit2 = 1).
module uart_rx #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus,
  input  logic      baud_tick,
  input  logic      serialIn
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TICK_W = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Line synchronizer; idles high so reset never looks like a start bit.
  logic [1:0] sync_q;
  logic       line;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], serialIn};
  end

  assign line = sync_q[1];

  rx_state_e          state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BYTE_W-1:0]  shift_q, shift_d;
  logic               push_c;
  logic               ferr_set_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Receive sequencing; every decision is gated by a baud tick.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    if (baud_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!line) begin
            tick_d  = '0;
            state_d = ST_START;
          end
        end
        ST_START: begin
          if (tick_q == TICK_W'(7)) begin
            if (line) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              tick_d  = '0;
              idx_d   = '0;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        ST_DATA: begin
          // Counter wraps 15 -> 0, re-arming for the next mid-bit sample.
          tick_d = tick_q + TICK_W'(1);
          if (tick_q == TICK_W'(15)) begin
            shift_d[idx_q] = line;
            if (idx_q == IDX_W'(7)) state_d = ST_STOP;
            else                    idx_d   = idx_q + IDX_W'(1);
          end
        end
        ST_STOP: begin
          tick_d = tick_q + TICK_W'(1);
          if (tick_q == TICK_W'(15)) begin
            if (line) begin
              push_c  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_set_c = 1'b1;
              state_d    = ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (line) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  logic [BYTE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              empty_c, full_c;
  logic              ovr_q, ferr_q;
  logic              ready_q;
  logic [31:0]       rdata_q, rdata_c;
  logic              req_c, is_status_c, is_write_c;
  logic              pop_c, push_ok_c, ovr_set_c, clr_c;

  assign empty_c     = (count_q == '0);
  assign full_c      = (count_q == CNT_W'(FIFO_DEPTH));
  assign req_c       = bus.mem_valid & bus.enable & ~ready_q;
  assign is_status_c = bus.mem_addr[2];
  assign is_write_c  = |bus.mem_wstrb;
  assign pop_c       = req_c & ~is_write_c & ~is_status_c & ~empty_c;
  assign clr_c       = req_c & is_write_c & is_status_c;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok_c   = push_c & (~full_c | pop_c);
  assign ovr_set_c   = push_c & full_c & ~pop_c;

  always_ff @(posedge clk) begin
    if (push_ok_c) fifo_mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Set wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_set_c  | (ovr_q  & ~clr_c);
      ferr_q <= ferr_set_c | (ferr_q & ~clr_c);
    end
  end

  // Register read mux; writes and empty DATA reads return zero.
  always_comb begin
    rdata_c = '0;
    if (!is_write_c) begin
      if (is_status_c)  rdata_c = {23'b0, 5'(count_q), ferr_q, ovr_q, full_c, ~empty_c};
      else if (!empty_c) rdata_c = {24'b0, fifo_mem[rd_ptr_q]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= req_c;
      rdata_q <= req_c ? rdata_c : '0;
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;

  logic unused_bus;
  assign unused_bus = ^{bus.mem_instr, bus.mem_wdata, bus.mem_addr[31:3], bus.mem_addr[1:0]};

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames in, register reads out,
// read data checked against an expected-value queue as mem_ready appears.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b0;
  logic       serialIn = 1'b1;
  logic [1:0] div = 2'd0;

  always #5 clk = ~clk;

  // One tick every 4 clocks: 64 clocks per bit.
  always @(posedge clk) begin
    div       <= div + 2'd1;
    baud_tick <= (div == 2'd3);
  end

  uart_rx_if u_if ();

  uart_rx #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (u_if),
    .baud_tick (baud_tick),
    .serialIn  (serialIn)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q  [$];
  string       name_q [$];

  typedef struct {
    logic        status;
    logic [3:0]  wstrb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard side: every ready pulse consumes one expected value.
  always @(negedge clk) begin
    logic [31:0] e;
    string       nm;
    if (u_if.mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected mem_ready", 32'd1, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, u_if.mem_rdata, e);
      end
    end else begin
      check("rdata zero while idle", u_if.mem_rdata, 32'd0);
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) @(negedge clk iff baud_tick == 1'b1);
  endtask

  // Called on a falling edge; returns on a falling edge.
  task automatic bus_xfer(input logic status, input logic [3:0] wstrb,
                          input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    u_if.mem_addr  = status ? 32'h4 : 32'h0;
    u_if.mem_wstrb = wstrb;
    u_if.mem_wdata = 32'h0;
    u_if.mem_valid = 1'b1;
    @(posedge clk); #1;
    check({name, " ready latency"}, 32'(u_if.mem_ready), 32'd1);
    @(negedge clk);
    u_if.mem_valid = 1'b0;
    @(posedge clk); #1;
    check({name, " ready single cycle"}, 32'(u_if.mem_ready), 32'd0);
    @(negedge clk);
  endtask

  function automatic void addv(input logic status, input logic [3:0] wstrb,
                               input logic [31:0] exp, input string name);
    vec_t v;
    v.status = status;
    v.wstrb  = wstrb;
    v.exp    = exp;
    v.name   = name;
    vecs.push_back(v);
  endfunction

  task automatic run_table();
    foreach (vecs[i]) bus_xfer(vecs[i].status, vecs[i].wstrb, vecs[i].exp, vecs[i].name);
    vecs.delete();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    wait_ticks(1);
    serialIn = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      serialIn = b[i];
      wait_ticks(16);
    end
    serialIn = stop;
    wait_ticks(16);
  endtask

  initial begin
    u_if.enable    = 1'b1;
    u_if.mem_valid = 1'b0;
    u_if.mem_instr = 1'b0;
    u_if.mem_addr  = 32'h0;
    u_if.mem_wstrb = 4'h0;
    u_if.mem_wdata = 32'h0;
    reset          = 1'b1;
    repeat (3) @(negedge clk);
    check("ready low in reset", 32'(u_if.mem_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    addv(1'b1, 4'h0, 32'h0, "status after reset");
    run_table();

    // Single byte then drain.
    send_frame(8'h55, 1'b1);
    wait_ticks(4);
    addv(1'b0, 4'h0, 32'h55, "data 0x55");
    addv(1'b1, 4'h0, 32'h0,  "status after 0x55");
    run_table();

    // Short low glitch must not start a frame.
    wait_ticks(1);
    serialIn = 1'b0;
    wait_ticks(3);
    serialIn = 1'b1;
    wait_ticks(32);
    addv(1'b1, 4'h0, 32'h0, "status after glitch");
    run_table();

    // Overrun: fifth byte into a depth-4 FIFO is dropped.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      wait_ticks(4);
    end
    addv(1'b1, 4'h0, 32'h47, "status full+overrun");  // count 4, ovr, full, not empty
    addv(1'b0, 4'h0, 32'h01, "data 1");
    addv(1'b0, 4'h0, 32'h02, "data 2");
    addv(1'b0, 4'h0, 32'h03, "data 3");
    addv(1'b0, 4'h0, 32'h04, "data 4");
    addv(1'b1, 4'h0, 32'h04, "status overrun empty");
    addv(1'b0, 4'h0, 32'h00, "data read empty");
    addv(1'b0, 4'hF, 32'h00, "data write");
    addv(1'b1, 4'h0, 32'h04, "status after data write");
    addv(1'b1, 4'hF, 32'h00, "status clear");
    addv(1'b1, 4'h0, 32'h00, "status after clear");
    run_table();

    // Framing error, long break, then recovery.
    send_frame(8'hA5, 1'b0);
    wait_ticks(16 * 40);
    addv(1'b1, 4'h0, 32'h08, "status framing in break");
    run_table();
    serialIn = 1'b1;
    wait_ticks(32);
    send_frame(8'h3C, 1'b1);
    wait_ticks(4);
    addv(1'b1, 4'h0, 32'h19, "status after break frame");
    addv(1'b0, 4'h0, 32'h3C, "data 0x3C");
    addv(1'b1, 4'hF, 32'h00, "status clear framing");
    addv(1'b1, 4'h0, 32'h00, "status after framing clear");
    run_table();

    // Reset mid-frame with a byte already buffered.
    send_frame(8'h99, 1'b1);
    wait_ticks(4);
    wait_ticks(1);
    serialIn = 1'b0;
    wait_ticks(16);
    serialIn = 1'b1;
    wait_ticks(16);
    serialIn = 1'b0;
    wait_ticks(16 * 2 + 8);
    serialIn = 1'b1;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_ticks(40);
    addv(1'b1, 4'h0, 32'h0, "status after mid-frame reset");
    run_table();
    send_frame(8'h7E, 1'b1);
    wait_ticks(4);
    addv(1'b0, 4'h0, 32'h7E, "data 0x7E");
    addv(1'b1, 4'h0, 32'h0,  "status after 0x7E");
    run_table();

    // Pop lands on the same edge as a push into a full FIFO.
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h11 + 8'(i), 1'b1);
      wait_ticks(4);
    end
    fork
      send_frame(8'h15, 1'b1);
      begin
        wait_ticks(1);
        wait_ticks(153);
        bus_xfer(1'b0, 4'h0, 32'h11, "data 0x11 with push");
      end
    join
    wait_ticks(4);
    addv(1'b1, 4'h0, 32'h43, "status full no overrun");
    addv(1'b0, 4'h0, 32'h12, "data 0x12");
    addv(1'b0, 4'h0, 32'h13, "data 0x13");
    addv(1'b0, 4'h0, 32'h14, "data 0x14");
    addv(1'b0, 4'h0, 32'h15, "data 0x15");
    addv(1'b1, 4'h0, 32'h00, "status drained");
    run_table();

    repeat (4) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
